// File: rtl/aud_cic_mc_pkg.sv
// Shared types and helpers for the multi-channel CIC decimator and its scaler.
package aud_cic_mc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COMB = 1'b1
  } cic_state_e;

  // The comb engine needs CHANNELS cycles plus one hand-off cycle per frame.
  function automatic int unsigned clamp_decim(input int unsigned ratio,
                                              input int unsigned min_ratio);
    return (ratio < min_ratio) ? min_ratio : ratio;
  endfunction

  function automatic int unsigned limit_shift(input int unsigned amount,
                                              input int unsigned max_amount);
    return (amount > max_amount) ? max_amount : amount;
  endfunction

endpackage

// File: rtl/aud_cic_scale.sv
// Round-half-up arithmetic right shift followed by saturation, WIDTH -> BITS.
module aud_cic_scale
  import aud_cic_mc_pkg::*;
#(
  parameter int WIDTH      = 48,
  parameter int BITS       = 16,
  parameter int SHIFT_BITS = 6
) (
  input  logic signed [WIDTH-1:0]      din_i,
  input  logic        [SHIFT_BITS-1:0] shift_i,
  output logic signed [BITS-1:0]       dout_o
);

  localparam logic signed [WIDTH:0] MAX_V = {{(WIDTH-BITS+2){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [WIDTH:0] MIN_V = ~MAX_V;

  int unsigned             sh;
  logic signed [WIDTH:0]   wide;
  logic signed [WIDTH:0]   rnd;
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH:0]   y;

  // One extra bit keeps the rounding add from overflowing near full scale.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    rnd  = '0;
    sh   = limit_shift(32'(shift_i), WIDTH - 1);
    wide = {din_i[WIDTH-1], din_i};
    if (sh != 0) rnd = (WIDTH+1)'(1) << (sh - 1);
    sum = wide + rnd;
    y   = sum >>> sh;
    if (y > MAX_V)      dout_o = MAX_V[BITS-1:0];
    else if (y < MIN_V) dout_o = MIN_V[BITS-1:0];
    else                dout_o = y[BITS-1:0];
  end

endmodule

// File: rtl/aud_cic_mc.sv
// Multi-channel CIC decimator: per-channel integrator banks at the tick rate and
// one time-multiplexed comb engine that serves one channel per clock.
module aud_cic_mc
  import aud_cic_mc_pkg::*;
#(
  parameter int WIDTH      = 48,
  parameter int BITS       = 16,
  parameter int STAGES     = 5,
  parameter int CHANNELS   = 2,
  parameter int DECIM_BITS = 12,
  parameter int SHIFT_BITS = 6
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     in_tick,
  input  logic [CHANNELS*BITS-1:0] x_in,
  input  logic [DECIM_BITS-1:0]    decim,
  input  logic [SHIFT_BITS-1:0]    shift,
  output logic [CHANNELS*BITS-1:0] x_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun
);

  localparam int              CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  logic [DECIM_BITS-1:0]   decim_clamped;
  logic [DECIM_BITS-1:0]   count_q;
  logic [DECIM_BITS-1:0]   decim_act_q;
  logic                    wrap;
  logic signed [WIDTH-1:0] integ_last [CHANNELS];
  logic signed [WIDTH-1:0] snap_q     [CHANNELS];

  assign decim_clamped = DECIM_BITS'(clamp_decim(32'(decim), CHANNELS + 2));
  assign wrap          = in_tick && (count_q == decim_act_q - DECIM_BITS'(1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [WIDTH-1:0] integ_q [STAGES];
    logic signed [WIDTH-1:0] x_ext;

    assign x_ext = {{(WIDTH-BITS){x_in[c*BITS+BITS-1]}}, x_in[c*BITS +: BITS]};

    always_ff @(posedge CLK) begin
      if (!RSTb) begin
        for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
      end else if (in_tick) begin
        // NOTE: non-blocking assignments make each stage add its predecessor's pre-tick value.
        integ_q[0] <= integ_q[0] + x_ext;
        for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end

    assign integ_last[c] = integ_q[STAGES-1];
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      count_q     <= '0;
      decim_act_q <= decim_clamped;
      for (int c = 0; c < CHANNELS; c++) snap_q[c] <= '0;
    end else if (in_tick) begin
      if (wrap) begin
        count_q     <= '0;
        decim_act_q <= decim_clamped;
        for (int c = 0; c < CHANNELS; c++) snap_q[c] <= integ_last[c];
      end else begin
        count_q <= count_q + DECIM_BITS'(1);
      end
    end
  end

  cic_state_e      state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            comb_en;
  logic            frame_done;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    comb_en    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wrap) begin
          state_d = ST_COMB;
          ch_d    = '0;
        end
      end
      ST_COMB: begin
        comb_en = 1'b1;
        if (ch_q == LAST_CH) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shared comb chain: the selected channel's delays feed a purely combinational cascade.
  logic signed [WIDTH-1:0] dly_q [CHANNELS][STAGES];
  logic signed [WIDTH-1:0] diff  [STAGES+1];
  logic signed [BITS-1:0]  y_s;

  always_comb begin
    diff[0] = snap_q[ch_q];
    for (int k = 0; k < STAGES; k++) diff[k+1] = diff[k] - dly_q[ch_q][k];
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      // NOTE: the delay array is ordinary flops and must be cleared, or stale history leaks into the first frames.
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < STAGES; k++) dly_q[c][k] <= '0;
    end else if (comb_en) begin
      for (int k = 0; k < STAGES; k++) dly_q[ch_q][k] <= diff[k];
    end
  end

  aud_cic_scale #(
    .WIDTH      (WIDTH),
    .BITS       (BITS),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_scale (
    .din_i   (diff[STAGES]),
    .shift_i (shift),
    .dout_o  (y_s)
  );

  logic [CHANNELS*BITS-1:0] stage_q, frame_d;
  logic [CHANNELS*BITS-1:0] x_out_q, x_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     accept;

  // The last channel bypasses staging so the frame reaches x_out one cycle earlier.
  always_comb begin
    frame_d = stage_q;
    frame_d[int'(ch_q)*BITS +: BITS] = y_s;
    accept      = out_valid_q & out_ready;
    out_valid_d = out_valid_q & ~accept;
    x_out_d     = x_out_q;
    overrun_d   = 1'b0;
    if (frame_done) begin
      if (!out_valid_q || accept) begin
        x_out_d     = frame_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      stage_q     <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (comb_en) stage_q <= frame_d;
      x_out_q     <= x_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign x_out     = x_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
